// File: rtl/pipe_pkg.sv
// Shared widths, control-field layout and stage-boundary structs for the pipeline registers.
package pipe_pkg;

  localparam int PC_W    = 32;
  localparam int REG_W   = 32;
  localparam int RADDR_W = 5;

  // Control-bus bit offsets (LSB first); an all-zero bus is a bubble.
  localparam int CTRL_ALU_LSB         = 0;
  localparam int CTRL_ALU_W           = 4;
  localparam int CTRL_WB_WRITE_EN     = 4;
  localparam int CTRL_WB_DATA_SEL_LSB = 5;
  localparam int CTRL_PC_SEL          = 7;
  localparam int CTRL_MEM_EN          = 8;
  localparam int CTRL_MEM_WRITE       = 9;
  localparam int CTRL_RD_LSB          = 10;

  typedef struct packed {
    logic               spare;
    logic [RADDR_W-1:0] rd;
    logic               mem_write;
    logic               mem_en;
    logic               pc_sel;
    logic [1:0]         wb_data_sel;
    logic               wb_write_en;
    logic [3:0]         alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc_next;
    logic [REG_W-1:0] read_data1;
    logic [REG_W-1:0] read_data2;
  } id_ex_t;

  typedef struct packed {
    logic [REG_W-1:0] alu_result;
    logic [REG_W-1:0] write_data;
    logic [PC_W-1:0]  pc_next;
  } ex_mem_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam int    DATA_W_DEF  = $bits(id_ex_t);
  localparam int    CTRL_W_DEF  = $bits(ctrl_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic is_bubble(input ctrl_t c);
    return c == CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+data+ctrl holding register; clear wins over load and zeroes ctrl only.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] next_data,
  input  logic [CTRL_W-1:0] next_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Data is left untouched on clear: it is meaningless while valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      ctrl  <= next_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready, flush-to-bubble and optional skid slot.
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid must not depend on ready, and held data stays stable until emitted or flushed.
  stage_state_e state, state_next;
  logic accept, emit;
  logic main_load, main_clear, main_from_skid, skid_load, skid_clear;
  logic skid_valid;
  logic [DATA_W-1:0] skid_data, main_next_data;
  logic [CTRL_W-1:0] skid_ctrl, main_next_ctrl;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      // The instruction arriving with a flush is on the squashed path and is dropped.
      state_next = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          main_load  = 1'b1;
          state_next = ST_ONE;
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = ST_FULL;
          end else if (emit) begin
            main_clear = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: if (emit) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_next     = ST_ONE;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // With a skid slot ready depends only on flops; without it ready passes straight through.
  always_comb begin
    if (SKID != 0) in_ready = (state != ST_FULL);
    else           in_ready = out_ready | ~out_valid;
  end

  assign main_next_data = main_from_skid ? skid_data : in_data;
  assign main_next_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .next_data (main_next_data),
    .next_ctrl (main_next_ctrl),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .next_data (in_data),
      .next_ctrl (in_ctrl),
      .valid     (skid_valid),
      .data      (skid_data),
      .ctrl      (skid_ctrl)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign unused_skid = skid_load ^ skid_clear;
    assign skid_valid  = 1'b0;
    assign skid_data   = '0;
    assign skid_ctrl   = '0;
  end

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating; deliberately survives flush so stalls across squashes are still counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances checked against a queue model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam int CW = 16;
  localparam int W  = DW + CW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [1:0]    occ1, occ0;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0]   stall_cnt1, stall_cnt0, exp_stall1, exp_stall0;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt0)
`endif
  );

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input logic [7:0] d);
    return {8'hC3, d};
  endfunction

  // driver
  task automatic drive(input logic iv, input logic [7:0] d, input logic rdy, input logic fl);
    in_valid  = iv;
    in_data   = DW'(d);
    in_ctrl   = ctrl_of(d);
    out_ready = rdy;
    flush     = fl;
  endtask

  // scoreboard: compare both instances against their queues
  task automatic check_models();
    logic [W-1:0] e;
    chk("out_valid1", W'(out_valid1), W'(exp_q1.size() > 0));
    chk("occupancy1", W'(occ1), W'(exp_q1.size()));
    chk("in_ready1", W'(in_ready1), W'(exp_q1.size() < 2));
    if (exp_q1.size() > 0) begin
      e = exp_q1[0];
      chk("out_data1", W'(out_data1), W'(e[W-1:CW]));
      chk("out_ctrl1", W'(out_ctrl1), W'(e[CW-1:0]));
    end else chk("out_ctrl1_bubble", W'(out_ctrl1), '0);
    chk("out_valid0", W'(out_valid0), W'(exp_q0.size() > 0));
    chk("occupancy0", W'(occ0), W'(exp_q0.size()));
    if (exp_q0.size() > 0) begin
      e = exp_q0[0];
      chk("out_data0", W'(out_data0), W'(e[W-1:CW]));
      chk("out_ctrl0", W'(out_ctrl0), W'(e[CW-1:0]));
    end else chk("out_ctrl0_bubble", W'(out_ctrl0), '0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt1", W'(stall_cnt1), W'(exp_stall1));
    chk("stall_cnt0", W'(stall_cnt0), W'(exp_stall0));
`endif
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    logic acc1, emit1, acc0, emit0;
    logic [W-1:0] ent;
    #1;
    chk("in_ready1_pre", W'(in_ready1), W'(exp_q1.size() < 2));
    chk("in_ready0_pre", W'(in_ready0), W'(out_ready || exp_q0.size() == 0));
    acc1  = in_valid && exp_q1.size() < 2;
    emit1 = exp_q1.size() > 0 && out_ready;
    acc0  = in_valid && (out_ready || exp_q0.size() == 0);
    emit0 = exp_q0.size() > 0 && out_ready;
    ent   = {in_data, in_ctrl};
`ifdef PIPE_STAGE_STALL_CNT_EN
    if (exp_q1.size() > 0 && !out_ready && exp_stall1 != 32'hFFFF_FFFF) exp_stall1++;
    if (exp_q0.size() > 0 && !out_ready && exp_stall0 != 32'hFFFF_FFFF) exp_stall0++;
`endif
    @(posedge clk);
    if (flush) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      if (emit1) void'(exp_q1.pop_front());
      if (acc1) exp_q1.push_back(ent);
      if (emit0) void'(exp_q0.pop_front());
      if (acc0) exp_q0.push_back(ent);
    end
    #1;
    check_models();
  endtask

  task automatic clear_models();
    exp_q1.delete();
    exp_q0.delete();
`ifdef PIPE_STAGE_STALL_CNT_EN
    exp_stall1 = '0;
    exp_stall0 = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    clear_models();
    #1;
    check_models();
    chk("out_data1_rst", W'(out_data1), '0);
    chk("out_data0_rst", W'(out_data0), '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       iv;
    logic       rdy;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eocc;
    logic       eir;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'd1,  1'b1, 8'd1, 2'd1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'd2,  1'b1, 8'd2, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'd3,  1'b1, 8'd3, 2'd1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'd0,  1'b0, 8'd0, 2'd0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'd7,  1'b1, 8'd7, 2'd1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'd8,  1'b1, 8'd7, 2'd2, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'd99, 1'b1, 8'd7, 2'd2, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'd0,  1'b1, 8'd8, 2'd1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'd0,  1'b0, 8'd0, 2'd0, 1'b1};

    do_reset();

    // Streaming and skid stall, SKID=1 instance against the table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].rdy, 1'b0);
      step();
      chk($sformatf("tbl%0d_valid", i), W'(out_valid1), W'(vecs[i].ev));
      chk($sformatf("tbl%0d_occ", i), W'(occ1), W'(vecs[i].eocc));
      chk($sformatf("tbl%0d_ready", i), W'(in_ready1), W'(vecs[i].eir));
      if (vecs[i].ev) begin
        chk($sformatf("tbl%0d_data", i), W'(out_data1), W'(vecs[i].ed));
        chk($sformatf("tbl%0d_ctrl", i), W'(out_ctrl1), W'(ctrl_of(vecs[i].ed)));
      end else chk($sformatf("tbl%0d_ctrl", i), W'(out_ctrl1), '0);
    end

    // Reset in the middle of a stream, checked before any clock edge
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid1", W'(out_valid1), '0);
    chk("midrst_ctrl1", W'(out_ctrl1), '0);
    chk("midrst_ready1", W'(in_ready1), W'(1'b1));
    chk("midrst_occ1", W'(occ1), '0);
    chk("midrst_valid0", W'(out_valid0), '0);
    chk("midrst_ready0", W'(in_ready0), W'(1'b1));
    clear_models();
    @(negedge clk);
    reset = 1'b1;

    // Flush while FULL with a simultaneous accept
    drive(1'b1, 8'd4, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'd5, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'd9, 1'b0, 1'b1);
    step();
    chk("flush_valid1", W'(out_valid1), '0);
    chk("flush_ctrl1", W'(out_ctrl1), '0);
    chk("flush_occ1", W'(occ1), '0);
    chk("flush_ready1", W'(in_ready1), W'(1'b1));
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_emit", W'(out_valid1), '0);
    end

    // SKID=0 combinational back-pressure
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    #1;
    chk("skid0_ready_low", W'(in_ready0), '0);
    out_ready = 1'b1;
    #1;
    chk("skid0_ready_high", W'(in_ready0), W'(1'b1));
    step();
    chk("skid0_pass_valid", W'(out_valid0), W'(1'b1));
    chk("skid0_pass_data", W'(out_data0), W'(8'h22));

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = {$urandom(), $urandom(), $urandom()};
      in_ctrl   = 16'($urandom());
      step();
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    do_reset();
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_cnt_5", W'(stall_cnt1), W'(32'd5));
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    step();
    chk("stall_cnt_after_flush", W'(stall_cnt1), W'(32'd5));
    chk("stall_cnt0_after_flush", W'(stall_cnt0), W'(32'd5));
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-stage register that replaces the fixed ID/EX, EX/MEM and MEM/WB latches.
- Carries a payload bus (operands, immediates, PC) and a control bus (write enables, selects) between stages.
- Adds a valid/ready handshake, stall back-pressure, flush-to-bubble and an optional skid slot, so every stage boundary in the core uses one module.

Parameters:
- DATA_W, 96: payload width in bits, e.g. PCNext+ReadData1+ReadData2 packed.
- CTRL_W, 16: control-bus width; all-zero encodes a bubble/NOP (no writeback, no mem access).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single slot with combinational ready.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream stage presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  payload from upstream
- in_ctrl  in  CTRL_W  control from upstream
- flush  in  1  squash all held contents (branch taken or exception)
- out_valid  out  1  downstream holds a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control; forced to zero whenever out_valid = 0
- occupancy  out  2  number of held entries (0..2; max 1 when SKID = 0)

Behaviour:
- Reset (async, reset = 0): out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0, skid slot invalid, in_ready = 1. Deassertion takes effect on the next rising edge.
- Handshakes:
  - Accept on in_valid & in_ready at a rising edge.
  - Emit on out_valid & out_ready.
  - Outputs only change at clock edges. Latency is 1 cycle from accept to out_valid when the stage is empty.
- SKID = 1, states EMPTY / ONE / FULL:
  - main = output register; skid = second register; in_ready = ~skid_valid, registered, so there is no combinational path from out_ready.
  - EMPTY: accept -> ONE (main loaded).
  - ONE: accept & emit -> ONE (main reloaded); accept only -> FULL (skid loaded); emit only -> EMPTY.
  - FULL: in_ready = 0. Emit -> ONE, skid moves into main.
  - Order is strictly FIFO; no entry is ever dropped or duplicated.
- SKID = 0:
  - in_ready = out_ready | ~out_valid (combinational).
  - States EMPTY / ONE only, with the same accept/emit rules.
- Flush:
  - Synchronous. At the edge where flush = 1: out_valid = 0, skid invalid, out_ctrl = 0, occupancy = 0, next state EMPTY.
  - Flush overrides a simultaneous accept: the incoming instruction is discarded, because it belongs to the squashed path.
  - out_data is not cleared (don't care while invalid).
- Simultaneous flush and reset: reset wins (async).
- Data registers load only on accept (clock-enable style) to save toggling; ctrl is zeroed on an invalidating edge.
- occupancy = main_valid + skid_valid, updated on the same edge.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[31:0], which increments every cycle with out_valid & ~out_ready and saturates at 32'hFFFF_FFFF.
  - Reset value 0; flush does not clear it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - Width constants PC_W = 32, REG_W = 32, RADDR_W = 5.
  - Control-field bit offsets (alu_ctrl, wb_write_en, wb_data_sel, pc_sel, mem_en, ...).
  - CTRL_BUBBLE = '0.
  - Packed struct typedefs per stage boundary (id_ex_t, ex_mem_t) whose widths feed DATA_W/CTRL_W.
- Sub-module pipe_slot: one valid+data+ctrl register with load/clear enables. It is instantiated once for main and once for skid when SKID = 1.

Test Plan:
- Reset mid-stream: hold in_valid = 1 with in_data = 0xA5, assert reset -> out_valid = 0, out_ctrl = 0, in_ready = 1 within the same cycle, without waiting for a clock.
- Streaming: out_ready = 1, push data 1,2,3 on consecutive cycles -> out_data = 1,2,3 one cycle later each; occupancy stays at 1.
- Stall (SKID = 1): out_ready = 0, push 7 then 8 -> occupancy = 2 and in_ready = 0 the next cycle. Release out_ready -> 7 then 8 emitted in order; in_ready returns to 1 after the first emit.
- Flush with simultaneous accept: state FULL, assert flush and in_valid with data 9 -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0; 9 is never emitted.
- SKID = 0 back-pressure: out_valid = 1, out_ready = 0 -> in_ready = 0 combinationally. Raise out_ready -> in_ready = 1 in the same cycle; accept and emit on the same edge.
- PIPE_STAGE_STALL_CNT_EN: hold a valid output with out_ready = 0 for 5 cycles -> stall_cnt = 5; a following flush leaves stall_cnt = 5.
